// File: rtl/car_pkg.sv
// Shared definitions for the car sprite blocks: FSM state encoding, default
// sprite dimensions and the car-index width helper.
package car_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DRAW = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } car_state_e;

  localparam int CAR_W_DEFAULT = 16;
  localparam int CAR_H_DEFAULT = 32;

  // Car index width never drops below one bit, even for a single car.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/car_sprite_sequencer_if.sv
// Frame-control and pixel-stream bundle between game logic, the sequencer
// and the pixel painter. iActive exists only when CAR_MASK_EN is defined.
interface car_sprite_sequencer_if
  import car_pkg::*;
#(
  parameter int NUM_CARS = 4,
  parameter int XW       = 10,
  parameter int YW       = 10
) ();

  localparam int IW = idx_width(NUM_CARS);

  logic                   iStart;
  logic [NUM_CARS*XW-1:0] iCarX;
  logic [NUM_CARS*YW-1:0] iCarY;
`ifdef CAR_MASK_EN
  logic [NUM_CARS-1:0]    iActive;
`endif
  logic                   iStall;
  logic                   oPintar;
  logic [XW-1:0]          oX;
  logic [YW-1:0]          oY;
  logic [IW-1:0]          oCarIdx;
  logic                   oBusy;
  logic                   oDone;

  // The sequencer drives the pixel stream and frame status.
  modport master (
    input  iStart, iCarX, iCarY,
`ifdef CAR_MASK_EN
    input  iActive,
`endif
    input  iStall,
    output oPintar, oX, oY, oCarIdx, oBusy, oDone
  );

  modport slave (
    output iStart, iCarX, iCarY,
`ifdef CAR_MASK_EN
    output iActive,
`endif
    output iStall,
    input  oPintar, oX, oY, oCarIdx, oBusy, oDone
  );

endinterface

// File: rtl/sprite_scan_counter.sv
// Column/row raster counter over one CAR_W x CAR_H sprite, with clear,
// advance and a last-pixel flag. Also exposes its next value for look-ahead.
module sprite_scan_counter #(
  parameter int  CAR_W = 16,
  parameter int  CAR_H = 32,
  localparam int CW    = $clog2(CAR_W),
  localparam int RW    = $clog2(CAR_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col_nxt,
  output logic [RW-1:0] row_nxt,
  output logic          last
);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end;

  assign col_end = (col == CW'(CAR_W - 1));
  assign last    = col_end && (row == RW'(CAR_H - 1));

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (clear) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (advance) begin
      if (col_end) begin
        col_nxt = '0;
        row_nxt = last ? '0 : row + RW'(1);
      end else begin
        col_nxt = col + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

endmodule

// File: rtl/car_sprite_sequencer.sv
// Scans NUM_CARS car sprites per frame and streams one pixel coordinate per
// accepted cycle. Optional per-car draw mask enabled by CAR_MASK_EN.
module car_sprite_sequencer
  import car_pkg::*;
#(
  parameter int NUM_CARS = 4,
  parameter int CAR_W    = CAR_W_DEFAULT,
  parameter int CAR_H    = CAR_H_DEFAULT,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input logic                    iClk,
  input logic                    iReset,
  car_sprite_sequencer_if.master bus
);

  localparam int IW = idx_width(NUM_CARS);
  localparam int CW = $clog2(CAR_W);
  localparam int RW = $clog2(CAR_H);

  car_state_e    state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [XW-1:0] snap_x [NUM_CARS];
  logic [YW-1:0] snap_y [NUM_CARS];
  logic [XW-1:0] x_base, x_base_nxt;
  logic [YW-1:0] y_base, y_base_nxt;
  logic          snap_en, clear, advance, last, car_on;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;

  logic          pintar_q, busy_q, done_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [IW-1:0] idx_q;

`ifdef CAR_MASK_EN
  logic [NUM_CARS-1:0] snap_active;
  assign car_on = snap_active[idx];
`else
  assign car_on = 1'b1;
`endif

  sprite_scan_counter #(
    .CAR_W (CAR_W),
    .CAR_H (CAR_H)
  ) u_scan (
    .clk     (iClk),
    .rst     (iReset),
    .clear   (clear),
    .advance (advance),
    .col_nxt (col_nxt),
    .row_nxt (row_nxt),
    .last    (last)
  );

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    x_base_nxt = x_base;
    y_base_nxt = y_base;
    snap_en    = 1'b0;
    clear      = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE: if (bus.iStart) begin
        snap_en   = 1'b1;
        idx_nxt   = '0;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        clear      = 1'b1;
        x_base_nxt = snap_x[idx];
        y_base_nxt = snap_y[idx];
        state_nxt  = car_on ? S_DRAW : S_NEXT;
      end
      // The displayed pixel is accepted whenever the painter is not stalling.
      S_DRAW: if (!bus.iStall) begin
        advance = 1'b1;
        if (last) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (idx == IW'(NUM_CARS - 1)) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx + IW'(1);
          state_nxt = S_LOAD;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Snapshot taken only at frame start, so mid-frame position updates cannot tear the frame.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      // NOTE: this small snapshot array is cleared on reset on purpose; larger storage would normally be left unreset.
      for (int k = 0; k < NUM_CARS; k++) begin
        snap_x[k] <= '0;
        snap_y[k] <= '0;
      end
`ifdef CAR_MASK_EN
      snap_active <= '0;
`endif
    end else if (snap_en) begin
      for (int k = 0; k < NUM_CARS; k++) begin
        snap_x[k] <= bus.iCarX[k*XW +: XW];
        snap_y[k] <= bus.iCarY[k*YW +: YW];
      end
`ifdef CAR_MASK_EN
      snap_active <= bus.iActive;
`endif
    end
  end

  // Outputs are registered from next-cycle values so they line up with the state they describe.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      x_base   <= '0;
      y_base   <= '0;
      pintar_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      x_base   <= x_base_nxt;
      y_base   <= y_base_nxt;
      pintar_q <= (state_nxt == S_DRAW);
      busy_q   <= (state_nxt != S_IDLE);
      done_q   <= (state_nxt == S_DONE);
      if (state_nxt == S_DRAW) begin
        x_q <= x_base_nxt + XW'(col_nxt);
        y_q <= y_base_nxt + YW'(row_nxt);
      end
      if (state_nxt inside {S_LOAD, S_DRAW, S_NEXT}) idx_q <= idx_nxt;
    end
  end

  assign bus.oPintar = pintar_q;
  assign bus.oX      = x_q;
  assign bus.oY      = y_q;
  assign bus.oCarIdx = idx_q;
  assign bus.oBusy   = busy_q;
  assign bus.oDone   = done_q;

endmodule

// File: tb/tb_car_sprite_sequencer.sv
// Scoreboard bench for car_sprite_sequencer (2 cars, 2x2 sprites). Define
// CAR_MASK_EN to also exercise the per-car draw mask.
module tb_car_sprite_sequencer;

  localparam int NUM_CARS = 2;
  localparam int XW = 10;
  localparam int YW = 10;

  logic clk = 1'b0;
  logic rst;
  int   cyc;
  int   n_checks = 0;
  int   n_errors = 0;
  int   t0;

  logic [31:0] pix_q[$];
  int          done_q[$];

  car_sprite_sequencer_if #(.NUM_CARS(NUM_CARS), .XW(XW), .YW(YW)) bus ();

  car_sprite_sequencer #(
    .NUM_CARS (NUM_CARS),
    .CAR_W    (2),
    .CAR_H    (2),
    .XW       (XW),
    .YW       (YW)
  ) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int idx, input int x, input int y);
    logic [31:0] v;
    v = '0;
    v[20]    = idx[0];
    v[19:10] = x[9:0];
    v[9:0]   = y[9:0];
    return v;
  endfunction

  task automatic exp_pix(input int idx, input int x, input int y);
    pix_q.push_back(pk(idx, x, y));
  endtask

  // Hand-ordered 2x2 raster: (x,y) (x+1,y) (x,y+1) (x+1,y+1).
  task automatic exp_car(input int idx, input int x, input int y);
    exp_pix(idx, x, y);
    exp_pix(idx, x + 1, y);
    exp_pix(idx, x, y + 1);
    exp_pix(idx, x + 1, y + 1);
  endtask

  task automatic set_cars(input int x0, input int y0, input int x1, input int y1);
    bus.iCarX = {10'(x1), 10'(y0 - y0 + x0)};
    bus.iCarY = {10'(y1), 10'(y0)};
  endtask

  task automatic start_frame(output int edge_cyc);
    @(posedge clk); #1 bus.iStart = 1'b1;
    @(posedge clk); #1 bus.iStart = 1'b0;
    edge_cyc = cyc;
  endtask

  task automatic next_edge();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((pix_q.size() != 0 || done_q.size() != 0) && i < 200) begin
      @(posedge clk);
      i++;
    end
    n_checks++;
    if (pix_q.size() != 0 || done_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: %0d pixels and %0d done pulses outstanding, expected 0",
               name, pix_q.size(), done_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented pixel and every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (bus.oPintar) begin
      if (pix_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pixel: got car %0d (%0d,%0d), expected none",
                 bus.oCarIdx, bus.oX, bus.oY);
      end else if (bus.iStall) begin
        check("stalled_pixel", {11'd0, bus.oCarIdx, bus.oX, bus.oY}, pix_q[0]);
      end else begin
        check("pixel", {11'd0, bus.oCarIdx, bus.oX, bus.oY}, pix_q.pop_front());
      end
    end
    if (bus.oDone) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.iStart  = 1'b0;
    bus.iStall  = 1'b0;
    bus.iCarX   = '0;
    bus.iCarY   = '0;
`ifdef CAR_MASK_EN
    bus.iActive = 2'b11;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_pintar", bus.oPintar, 0);
    check("reset_busy",   bus.oBusy,   0);
    check("reset_done",   bus.oDone,   0);
    check("reset_x",      bus.oX,      0);
    check("reset_y",      bus.oY,      0);
    check("reset_idx",    bus.oCarIdx, 0);

    // Basic frame.
    set_cars(10, 20, 100, 50);
    exp_car(0, 10, 20);
    exp_car(1, 100, 50);
    start_frame(t0);
    done_q.push_back(t0 + 12);
    @(negedge clk);
    check("busy_in_frame", bus.oBusy, 1);
    drain("basic");
    check("idle_after_frame", bus.oBusy, 0);

    // Stall 3 cycles on the second pixel, then stall during NEXT/LOAD (no effect).
    exp_car(0, 10, 20);
    exp_car(1, 100, 50);
    start_frame(t0);
    done_q.push_back(t0 + 15);
    next_edge();
    next_edge();
    bus.iStall = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.iStall = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.iStall = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.iStall = 1'b0;
    drain("stall");

    // Coordinate wrap.
    set_cars(1023, 1023, 500, 1022);
    exp_pix(0, 1023, 1023);
    exp_pix(0, 0, 1023);
    exp_pix(0, 1023, 0);
    exp_pix(0, 0, 0);
    exp_pix(1, 500, 1022);
    exp_pix(1, 501, 1022);
    exp_pix(1, 500, 1023);
    exp_pix(1, 501, 1023);
    start_frame(t0);
    done_q.push_back(t0 + 12);
    drain("wrap");

    // Start while busy and mid-frame position change are both ignored.
    set_cars(10, 20, 100, 50);
    exp_car(0, 10, 20);
    exp_car(1, 100, 50);
    start_frame(t0);
    done_q.push_back(t0 + 12);
    next_edge();
    next_edge();
    next_edge();
    set_cars(10, 20, 5, 5);
    bus.iStart = 1'b1;
    next_edge();
    bus.iStart = 1'b0;
    drain("snapshot");
    repeat (20) @(posedge clk);
    #1 check("idle_after_ignored_start", bus.oBusy, 0);

    // Reset mid-DRAW, then a fresh frame restarts at car 0.
    set_cars(10, 20, 100, 50);
    exp_car(0, 10, 20);
    exp_car(1, 100, 50);
    start_frame(t0);
    next_edge();
    next_edge();
    rst = 1'b1;
    next_edge();
    rst = 1'b0;
    pix_q.delete();
    @(negedge clk);
    check("midreset_pintar", bus.oPintar, 0);
    check("midreset_busy",   bus.oBusy,   0);
    check("midreset_done",   bus.oDone,   0);
    check("midreset_x",      bus.oX,      0);
    check("midreset_y",      bus.oY,      0);
    exp_car(0, 10, 20);
    exp_car(1, 100, 50);
    start_frame(t0);
    done_q.push_back(t0 + 12);
    drain("restart");

    // Start coincident with reset: reset wins, nothing starts.
    next_edge();
    rst        = 1'b1;
    bus.iStart = 1'b1;
    next_edge();
    rst        = 1'b0;
    bus.iStart = 1'b0;
    @(negedge clk);
    check("start_with_reset_busy", bus.oBusy, 0);
    repeat (8) @(posedge clk);
    #1 check("start_with_reset_idle", bus.oBusy, 0);

`ifdef CAR_MASK_EN
    // Only car 0 active: car 1 costs LOAD+NEXT and draws nothing.
    bus.iActive = 2'b01;
    exp_car(0, 10, 20);
    start_frame(t0);
    done_q.push_back(t0 + 8);
    drain("mask_01");

    // No car active: done still pulses, no pixels.
    bus.iActive = 2'b00;
    start_frame(t0);
    done_q.push_back(t0 + 4);
    drain("mask_00");
    bus.iActive = 2'b11;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
